// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode/condition encodings, flag bit positions and
// the per-opcode flag write mask.
package wisc_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
      OP_LW, OP_SW, OP_LLB, OP_LHB, OP_B, OP_BR, OP_PCS, OP_HLT
   } opcode_e;

   typedef enum logic [2:0] {
      CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UN
   } cond_e;

   typedef enum logic {S_RUN, S_HALTED} halt_e;

   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   // Which of {V,N,Z} an instruction writes when it retires from EX.
   function automatic logic [2:0] sets_flags(opcode_e op);
      case (op)
         OP_ADD, OP_SUB:                 sets_flags = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: sets_flags = 3'b001;
         default:                        sets_flags = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from the architectural {V,N,Z} flags.
module branch_cond
   import wisc_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] flags,
   output logic       take
);

   logic v, n, z;
   assign v = flags[FLAG_V];
   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];

   always_comb begin
      case (cond_e'(ccc))
         CC_NE:   take = !z;
         CC_EQ:   take = z;
         CC_GT:   take = !z & !n;
         CC_LT:   take = n;
         CC_GE:   take = z | (!z & !n);
         CC_LE:   take = n | z;
         CC_OV:   take = v;
         default: take = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_issue.sv
// WISC ID stage: decode, RF read, hazard stalls, branch resolution, ID/EX
// register feeding the ALU, and the architectural flag register.
module decode_issue
   import wisc_pkg::*;
#(
   parameter int DW  = 16,
   parameter int RA  = 4,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           if_valid,
   input  logic [15:0]    if_instr,
   input  logic [DW-1:0]  if_pc_plus2,
   output logic           id_ready,
   output logic [RA-1:0]  rf_addr1,
   output logic [RA-1:0]  rf_addr2,
   input  logic [DW-1:0]  rf_data1,
   input  logic [DW-1:0]  rf_data2,
   output logic           ex_valid,
   input  logic           ex_ready,
   output logic [OPW-1:0] ex_opcode,
   output logic [DW-1:0]  ex_operand1,
   output logic [DW-1:0]  ex_operand2,
   output logic [RA-1:0]  ex_dst,
   output logic           ex_wr_en,
   output logic           ex_mem_rd,
   output logic           ex_mem_wr,
   output logic [DW-1:0]  ex_store_data,
   input  logic [2:0]     alu_flags,
   output logic [2:0]     flags_q,
   output logic           br_taken,
   output logic [DW-1:0]  br_target,
   output logic           halted
);

   opcode_e         op, ex_op;
   halt_e           state, state_nx;
   logic [3:0]      rd, rs, rt, d_alu;
   logic [7:0]      imm8;
   logic [8:0]      imm9;
   logic [DW-1:0]   d_op1, d_op2, tgt;
   logic            issue, use1, use2, d_wr, d_mrd, d_mwr, is_br, take;
   logic            dec_valid, lu, fu, stall, load, accept, go;

   assign op   = opcode_e'(if_instr[15:12]);
   assign rd   = if_instr[11:8];
   assign rs   = if_instr[7:4];
   assign rt   = if_instr[3:0];
   assign imm8 = if_instr[7:0];
   assign imm9 = if_instr[8:0];

   always_comb begin
      issue = 1'b1;  use1 = 1'b1;  use2 = 1'b0;
      d_wr = 1'b1;   d_mrd = 1'b0; d_mwr = 1'b0;
      d_alu = op;    d_op1 = rf_data1; d_op2 = rf_data2;
      rf_addr1 = rs; rf_addr2 = rt;
      case (op)
         OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: use2 = 1'b1;
         OP_SLL, OP_SRA, OP_ROR: d_op2 = {{(DW-4){1'b0}}, rt};
         OP_LW, OP_SW: begin
            d_alu = OP_ADD;
            d_op1 = rf_data1 & {{(DW-1){1'b1}}, 1'b0};
            d_op2 = {{(DW-5){rt[3]}}, rt, 1'b0};
            if (op == OP_SW) begin
               rf_addr2 = rd; use2 = 1'b1; d_wr = 1'b0; d_mwr = 1'b1;
            end else begin
               d_mrd = 1'b1;
            end
         end
         OP_LLB: begin
            rf_addr1 = rd; d_alu = OP_XOR;
            d_op1 = rf_data1 & {{(DW-8){1'b1}}, 8'h00};
            d_op2 = {{(DW-8){1'b0}}, imm8};
         end
         OP_LHB: begin
            rf_addr1 = rd; d_alu = OP_XOR;
            d_op1 = rf_data1 & {{(DW-8){1'b0}}, 8'hFF};
            d_op2 = {imm8, {(DW-8){1'b0}}};
         end
         OP_PCS: begin
            use1 = 1'b0; d_alu = OP_ADD; d_op1 = if_pc_plus2; d_op2 = '0;
         end
         OP_BR: begin
            issue = 1'b0; d_wr = 1'b0;
         end
         default: begin
            issue = 1'b0; use1 = 1'b0; d_wr = 1'b0;
         end
      endcase
   end

   assign is_br = (op == OP_B) || (op == OP_BR);
   assign tgt   = (op == OP_BR) ? rf_data1
                                : if_pc_plus2 + {{(DW-10){imm9[8]}}, imm9, 1'b0};

   branch_cond u_cond (.ccc(if_instr[11:9]), .flags(flags_q), .take(take));

   // The slot right after a taken branch is wrong-path and is dropped.
   assign dec_valid = if_valid & !br_taken;
   assign lu = ex_valid & ex_mem_rd & (ex_dst != '0) &
               ((use1 & (ex_dst == rf_addr1)) | (use2 & (ex_dst == rf_addr2)));
   assign fu = is_br & ex_valid & (sets_flags(ex_op) != 3'b000);
   assign stall    = dec_valid & (lu | fu);
   assign load     = !ex_valid | ex_ready;
   assign id_ready = load & !stall & !halted;
   assign accept   = dec_valid & id_ready;
   assign go       = accept & issue;

   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == S_RUN && accept && op == OP_HLT) state_nx = S_HALTED;
   end

   always_comb begin
      halted = (state == S_HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0; ex_op <= OP_ADD; ex_opcode <= '0;
         ex_operand1 <= '0; ex_operand2 <= '0; ex_dst <= '0;
         ex_wr_en <= 1'b0; ex_mem_rd <= 1'b0; ex_mem_wr <= 1'b0;
         ex_store_data <= '0;
      end else if (load) begin
         ex_valid      <= go;
         ex_op         <= go ? op : OP_ADD;
         ex_opcode     <= go ? d_alu : '0;
         ex_operand1   <= go ? d_op1 : '0;
         ex_operand2   <= go ? d_op2 : '0;
         ex_dst        <= go ? rd : '0;
         ex_wr_en      <= go & d_wr;
         ex_mem_rd     <= go & d_mrd;
         ex_mem_wr     <= go & d_mwr;
         ex_store_data <= (go & d_mwr) ? rf_data2 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                       flags_q <= '0;
      else if (ex_valid & ex_ready)  flags_q <= (flags_q & ~sets_flags(ex_op)) |
                                                (alu_flags & sets_flags(ex_op));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         br_taken <= accept & is_br & take;
         if (accept & is_br & take) br_target <= tgt;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Directed-vector bench for decode_issue with a small register file model.
module tb_decode_issue;

   logic        clk, rst, if_valid, id_ready, ex_valid, ex_ready;
   logic [15:0] if_instr, if_pc_plus2, rf_data1, rf_data2;
   logic [3:0]  rf_addr1, rf_addr2, ex_opcode, ex_dst;
   logic [15:0] ex_operand1, ex_operand2, ex_store_data, br_target;
   logic        ex_wr_en, ex_mem_rd, ex_mem_wr, br_taken, halted;
   logic [2:0]  alu_flags, flags_q;
   logic [15:0] regs [16];
   int          nvec = 0, nerr = 0;

   decode_issue dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc_plus2(if_pc_plus2), .id_ready(id_ready),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_dst(ex_dst),
      .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_store_data(ex_store_data), .alu_flags(alu_flags), .flags_q(flags_q),
      .br_taken(br_taken), .br_target(br_target), .halted(halted)
   );

   assign rf_data1 = (rf_addr1 == 4'd0) ? 16'h0 : regs[rf_addr1];
   assign rf_data2 = (rf_addr2 == 4'd0) ? 16'h0 : regs[rf_addr2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 16'h0;
      regs[1] = 16'h0005; regs[2] = 16'h0003; regs[4] = 16'h0040; regs[6] = 16'h1234;
      rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0; if_pc_plus2 = 16'h0;
      ex_ready = 1'b1; alu_flags = 3'b000;
      tick(); tick();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_halted", halted, 0);
      chk("rst_br_taken", br_taken, 0);
      chk("rst_op1", ex_operand1, 0);
      rst = 1'b0;

      // ADD then SUB R3,R1,R2; ADD retires with VNZ=111, SUB with 000
      if_valid = 1'b1; if_instr = 16'h0312; #1;
      chk("add_ready", id_ready, 1);
      tick();
      chk("add_valid", ex_valid, 1);
      chk("add_opc", ex_opcode, 0);
      if_instr = 16'h1312; alu_flags = 3'b111;
      tick();
      chk("add_flags", flags_q, 3'b111);
      chk("sub_opc", ex_opcode, 1);
      chk("sub_op1", ex_operand1, 5);
      chk("sub_op2", ex_operand2, 3);
      chk("sub_dst", ex_dst, 3);
      chk("sub_wr", ex_wr_en, 1);
      if_valid = 1'b0; alu_flags = 3'b000;
      tick();
      chk("sub_flags", flags_q, 3'b000);
      chk("sub_drained", ex_valid, 0);

      // LW R4,2(R1) then ADD R5,R4,R2: load-use bubble
      if_valid = 1'b1; if_instr = 16'h8411;
      tick();
      chk("lw_opc", ex_opcode, 0);
      chk("lw_op1", ex_operand1, 4);
      chk("lw_op2", ex_operand2, 2);
      chk("lw_mrd", ex_mem_rd, 1);
      chk("lw_dst", ex_dst, 4);
      if_instr = 16'h0542; alu_flags = 3'b111; #1;
      chk("lu_stall", id_ready, 0);
      tick();
      chk("lu_bubble", ex_valid, 0);
      chk("lw_noflag", flags_q, 3'b000);
      chk("lu_release", id_ready, 1);
      chk("lu_addr1", rf_addr1, 4);
      tick();
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_op1", ex_operand1, 16'h0040);
      chk("lu_add_op2", ex_operand2, 3);
      chk("lu_add_dst", ex_dst, 5);

      // LHB R6,0xAB with R6=0x1234
      alu_flags = 3'b000; if_instr = 16'hB6AB; #1;
      chk("lhb_addr1", rf_addr1, 6);
      tick();
      chk("lhb_opc", ex_opcode, 2);
      chk("lhb_op1", ex_operand1, 16'h0034);
      chk("lhb_op2", ex_operand2, 16'hAB00);
      chk("lhb_dst", ex_dst, 6);
      if_valid = 1'b0; alu_flags = 3'b111;
      tick();
      chk("lhb_noflag", flags_q, 3'b000);

      // ADD in EX, B EQ,-2 at pc+2=0x0010 waits for it to retire with Z=1
      alu_flags = 3'b000; if_valid = 1'b1; if_instr = 16'h0712;
      tick();
      if_instr = 16'hC3FE; if_pc_plus2 = 16'h0010; ex_ready = 1'b0; #1;
      chk("fu_hold_ready", id_ready, 0);
      tick();
      chk("fu_hold_valid", ex_valid, 1);
      chk("fu_hold_br", br_taken, 0);
      ex_ready = 1'b1; alu_flags = 3'b001; #1;
      chk("fu_stall", id_ready, 0);
      tick();
      chk("fu_flags", flags_q, 3'b001);
      chk("fu_bubble", ex_valid, 0);
      chk("fu_release", id_ready, 1);
      alu_flags = 3'b000;
      tick();
      chk("beq_taken", br_taken, 1);
      chk("beq_target", br_target, 16'h000C);
      if_instr = 16'h0812;
      tick();
      chk("br_pulse", br_taken, 0);
      chk("wrong_path", ex_valid, 0);
      if_valid = 1'b0;

      // SW R2,0(R1) held in EX for 3 cycles
      tick();
      if_valid = 1'b1; if_instr = 16'h9210;
      tick();
      chk("sw_mwr", ex_mem_wr, 1);
      chk("sw_data", ex_store_data, 3);
      chk("sw_op1", ex_operand1, 4);
      chk("sw_wr", ex_wr_en, 0);
      ex_ready = 1'b0; alu_flags = 3'b111; if_instr = 16'h0312;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_ready", id_ready, 0);
         tick();
         chk("hold_valid", ex_valid, 1);
         chk("hold_mwr", ex_mem_wr, 1);
         chk("hold_data", ex_store_data, 3);
         chk("hold_op1", ex_operand1, 4);
         chk("hold_flags", flags_q, 3'b001);
      end
      ex_ready = 1'b1; alu_flags = 3'b110;
      tick();
      chk("sw_noflag", flags_q, 3'b001);
      chk("after_sw_op1", ex_operand1, 5);
      if_valid = 1'b0; alu_flags = 3'b000;
      tick();
      chk("add_clr_flags", flags_q, 3'b000);

      // BR always via R2, then B OV not taken
      if_valid = 1'b1; if_instr = 16'hDE20; #1;
      chk("br_addr1", rf_addr1, 2);
      tick();
      chk("br_taken", br_taken, 1);
      chk("br_target", br_target, 16'h0003);
      if_valid = 1'b0;
      tick();
      chk("br_pulse2", br_taken, 0);
      if_valid = 1'b1; if_instr = 16'hCC05;
      tick();
      chk("bov_not_taken", br_taken, 0);
      chk("bov_target", br_target, 16'h0003);

      // HLT accepted, then reset
      if_instr = 16'h0312;
      tick();
      alu_flags = 3'b111; if_instr = 16'hF000;
      tick();
      chk("hlt_halted", halted, 1);
      chk("hlt_flags", flags_q, 3'b111);
      chk("hlt_bubble", ex_valid, 0);
      if_instr = 16'h0312; alu_flags = 3'b000; #1;
      chk("hlt_ready", id_ready, 0);
      tick();
      chk("hlt_no_issue", ex_valid, 0);
      rst = 1'b1;
      tick();
      chk("rst2_halted", halted, 0);
      chk("rst2_flags", flags_q, 3'b000);
      chk("rst2_valid", ex_valid, 0);
      chk("rst2_br", br_taken, 0);
      rst = 1'b0; if_valid = 1'b0; #1;
      chk("rst2_ready", id_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
